led_pattern_gen: RTL
====================

# led_pattern_gen

Parametrised LED pattern generator driving the board LED bank from the system clock. It supersedes the fixed single-rate blinker in `Top`. It provides N LED channels, a run-time selectable rate (SW-driven), four display modes and a hold control. It sits in `Top` between the reset generator and the `LED` port, and exports its rate tick for reuse and verification.

## Interface
- `CLK_FREQ_HZ`, 50_000_000: input clock frequency.
- `TICK_HZ`, 1: base pattern step rate at speed 0.
- `NB_LED`, 8: number of LED outputs; must be ≥ 2.
- `clk`  in  1  system clock, single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mode`  in  2  display mode: 0 blink, 1 chase, 2 binary count, 3 breathe.
- `speed`  in  2  rate multiplier: step period = DIV >> speed.
- `hold`  in  1  1 = freeze prescaler and pattern.
- `led`  out  NB_LED  LED drive, 1 = lit.
- `tick`  out  1  one-cycle pulse on every pattern step.

## Operation
- DIV = CLK_FREQ_HZ / TICK_HZ (integer division). Elaboration fails if DIV < 16.
- Prescaler `cnt` is $clog2(DIV) bits wide. LIMIT = DIV >> speed, evaluated combinationally every cycle.
- Each cycle with hold = 0:
  - If cnt ≥ LIMIT-1: cnt ← 0 and a step occurs.
  - Otherwise cnt ← cnt+1.
  - The ≥ comparison covers a speed increase mid-count: the step fires on the next edge.
- hold = 1: cnt, pattern and breathe level are frozen and no step occurs. The PWM counter keeps running so the breathe output stays dimmed.
- Step behaviour per mode. In all cases `pat` is an NB_LED-bit register.
  - Mode 0, blink: pat ← ~pat. Init all-0.
  - Mode 1, chase: pat ← rotate-left(pat); bit NB_LED-1 wraps to bit 0. Init 1 (LED0 lit).
  - Mode 2, count: pat ← pat+1 mod 2^NB_LED. All-ones wraps to 0. Init 0.
  - Mode 3, breathe: 4-bit `level` triangle ramp 0→15→0. It reverses direction at 15 and at 0, so neither endpoint is repeated: the sequence is 0,1,…,15,14,…,1,0,1,… Init 0, rising.
- Breathe output:
  - `pwm` is a 4-bit free-running counter, incremented every clock.
  - In mode 3, every led bit = (pwm < level). Level 0 gives fully off; level 15 gives 15/16 duty.
- Mode change:
  - `mode_q` registers `mode`.
  - In any cycle where mode ≠ mode_q: mode_q ← mode, cnt ← 0, pat/level ← init value of the new mode, and no step occurs.
  - This takes priority over a step in the same cycle, and applies even while hold = 1.
- `led` = pat in modes 0–2, and the PWM compare in mode 3. The output is registered.

## Timing
- Reset (async assert, sync release on the next clk edge) clears:
  - cnt = 0, pwm = 0, level = 0 rising, mode_q = 0, pat = 0
  - led = 0, tick = 0
- After reset, the first step occurs LIMIT cycles after release.
- Step latency: at the edge where cnt reaches LIMIT-1, tick ← 1 and the new pattern appears on led at that same edge. tick is high for exactly 1 cycle.
- Step period with constant speed and hold = 0: exactly LIMIT cycles.
- Mode change latency: led shows the new mode's init value 1 cycle after `mode` changes.
- Breathe mode: led is registered from pwm/level, so it reflects the compare 1 cycle late.
- A reset asserted mid-operation clears all state immediately, with no clock required.

## Configuration
- `LED_PWM_EN` defined: mode 3 breathe, the pwm counter and the level register are compiled in as described.
- `LED_PWM_EN` undefined:
  - No pwm or level logic is built.
  - Mode 3 decodes exactly as mode 0 (blink, init all-0, toggles each step).
  - Changing between modes 0 and 3 still counts as a mode change and re-initialises state.

## Test plan
All scenarios use CLK_FREQ_HZ = 160, TICK_HZ = 10 (DIV = 16), NB_LED = 8.

- Reset: pulse reset_n low for 18 ns mid-run → led = 0x00 and tick = 0 asynchronously. After release with mode = 0, speed = 0, the first tick comes 16 cycles later and led = 0xFF.
- Chase and rate: mode = 1, speed = 2 → tick every 4 cycles. led sequence is 0x01, 0x02, …, 0x80, 0x01 (wrap). Switching to speed = 0 mid-count → next tick within ≤ 16 cycles, then every 16.
- Count wrap: mode = 2, speed = 3 (period 2) → led increments every 2 cycles. 0xFF → 0x00 on the 256th step.
- Hold and mode change:
  - hold = 1 for 40 cycles → no tick and led constant. Release → counting resumes from the frozen cnt.
  - Mode 2→1 while held → led = 0x01 the next cycle and cnt = 0.
- Breathe (`LED_PWM_EN` defined): mode = 3, speed = 0:
  - Over 16 cycles at level 0, led = 0x00 throughout.
  - After 15 steps (level 15), led = 0xFF for 15 of every 16 cycles.
  - Next step gives level 14.
- Breathe disabled (`LED_PWM_EN` undefined): mode = 3 → led toggles 0x00/0xFF each tick, identical to mode 0.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern generator: blink, chase, binary count and breathe modes.
// Define LED_PWM_EN to build breathe (pwm + level); otherwise mode 3 blinks.
module led_pattern_gen #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int NB_LED      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mode,
  input  logic [1:0]        speed,
  input  logic              hold,
  output logic [NB_LED-1:0] led,
  output logic              tick
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int CW  = $clog2(DIV);
  localparam logic [31:0]       DIV_U   = 32'(DIV);
  localparam logic [NB_LED-1:0] PAT_ONE = NB_LED'(1);
  localparam logic [CW-1:0]     CNT_ONE = CW'(1);

  generate
    if (DIV < 16) begin : g_div_chk
      $error("led_pattern_gen: DIV must be >= 16");
    end
    if (NB_LED < 2) begin : g_led_chk
      $error("led_pattern_gen: NB_LED must be >= 2");
    end
  endgenerate

  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [1:0]        r_mode_q;
  logic [NB_LED-1:0] r_pat;
  logic [NB_LED-1:0] w_pat_nxt;
  logic [NB_LED-1:0] r_led;
  logic [NB_LED-1:0] w_led_nxt;
  logic              r_tick;
  logic [31:0]       w_limit;
  logic [31:0]       w_cnt32;
  logic              w_mchg;
  logic              w_wrap;
  logic              w_step;
  logic              w_m_chase;
  logic              w_m_count;

  assign w_limit   = DIV_U >> speed;
  assign w_cnt32   = 32'(r_cnt);
  assign w_mchg    = (mode != r_mode_q);
  // >= rather than == so a mid-count speed-up steps on the next edge
  assign w_wrap    = (w_cnt32 >= (w_limit - 32'd1));
  assign w_step    = !hold && !w_mchg && w_wrap;
  assign w_m_chase = (r_mode_q == 2'd1);
  assign w_m_count = (r_mode_q == 2'd2);

`ifdef LED_PWM_EN
  logic       w_m_brth;
  logic [3:0] r_pwm;
  logic [3:0] r_level;
  logic [3:0] w_level_nxt;
  logic       r_up;
  logic       w_up_nxt;

  assign w_m_brth = (r_mode_q == 2'd3);
`endif

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_pat_nxt = r_pat;
    if (w_mchg) begin
      w_cnt_nxt = '0;
      w_pat_nxt = (mode == 2'd1) ? PAT_ONE : '0;
    end else if (!hold) begin
      if (w_wrap) begin
        w_cnt_nxt = '0;
        unique case (1'b1)
          w_m_chase: w_pat_nxt = {r_pat[NB_LED-2:0], r_pat[NB_LED-1]};
          w_m_count: w_pat_nxt = r_pat + PAT_ONE;
`ifdef LED_PWM_EN
          w_m_brth:  w_pat_nxt = r_pat;
`endif
          default:   w_pat_nxt = ~r_pat;
        endcase
      end else begin
        w_cnt_nxt = r_cnt + CNT_ONE;
      end
    end
  end

`ifdef LED_PWM_EN
  // Triangle ramp turns at both ends without repeating them
  always_comb begin
    w_level_nxt = r_level;
    w_up_nxt    = r_up;
    if (w_mchg) begin
      w_level_nxt = 4'd0;
      w_up_nxt    = 1'b1;
    end else if (w_step && w_m_brth) begin
      if (r_up) begin
        if (r_level == 4'd15) begin
          w_level_nxt = 4'd14;
          w_up_nxt    = 1'b0;
        end else begin
          w_level_nxt = r_level + 4'd1;
        end
      end else begin
        if (r_level == 4'd0) begin
          w_level_nxt = 4'd1;
          w_up_nxt    = 1'b1;
        end else begin
          w_level_nxt = r_level - 4'd1;
        end
      end
    end
  end

  assign w_led_nxt = (mode == 2'd3) ?
                     {NB_LED{r_pwm < r_level}} : w_pat_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm   <= 4'd0;
      r_level <= 4'd0;
      r_up    <= 1'b1;
    end else begin
      r_pwm   <= r_pwm + 4'd1;
      r_level <= w_level_nxt;
      r_up    <= w_up_nxt;
    end
  end
`else
  assign w_led_nxt = w_pat_nxt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_mode_q <= 2'd0;
      r_pat    <= '0;
      r_led    <= '0;
      r_tick   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_mode_q <= mode;
      r_pat    <= w_pat_nxt;
      r_led    <= w_led_nxt;
      r_tick   <= w_step;
    end
  end

  assign led  = r_led;
  assign tick = r_tick;

endmodule
